// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Shadow entry layout, zero-register test and forward-select constants.
package hazard_pkg;

    localparam int RD_MAX_W    = 8;
    localparam int ZERO_S      = 0;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } shadow_entry_t;

    // Scalar x0 and vector v0 share the low bits; only the file-select bit differs.
    function automatic logic is_zero_reg(
        input logic [RD_MAX_W-1:0] r,
        input int                  reg_w
    );
        logic [RD_MAX_W-1:0] vbit;
        vbit = RD_MAX_W'(1) << (reg_w - 1);
        return (r & ~vbit) == RD_MAX_W'(ZERO_S);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle.
// Stats counters exist only when HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_wr;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             stall;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [DEPTH-1:0] busy_mask;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_wr, id_is_load, ex_branch_taken,
        input  stall, flush_if_id, flush_id_ex,
        input  fwd_a_sel, fwd_b_sel, busy_mask,
        input  stall_cycles, flush_count
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_wr, id_is_load, ex_branch_taken,
        output stall, flush_if_id, flush_id_ex,
        output fwd_a_sel, fwd_b_sel, busy_mask,
        output stall_cycles, flush_count
    );
`else
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_wr, id_is_load, ex_branch_taken,
        input  stall, flush_if_id, flush_id_ex,
        input  fwd_a_sel, fwd_b_sel, busy_mask
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_wr, id_is_load, ex_branch_taken,
        output stall, flush_if_id, flush_id_ex,
        output fwd_a_sel, fwd_b_sel, busy_mask
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_match.sv
// Youngest-producer search for one source operand.
// Lowest shadow stage holding a matching destination wins.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  shadow_entry_t [DEPTH-1:0] ent,
    input  logic [REG_W-1:0]          src,
    input  logic                      use_src,
    output logic                      hit,
    output logic [SEL_W-1:0]          stage,
    output logic                      is_load
);

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        if (use_src && !is_zero_reg(RD_MAX_W'(src), REG_W)) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (ent[s].valid && ent[s].rd == RD_MAX_W'(src)) begin
                    hit     = 1'b1;
                    stage   = SEL_W'(s);
                    is_load = ent[s].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control over a tag shadow pipeline.
// Optional saturating stall/flush counters: define HAZARD_STATS_EN.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    shadow_entry_t [DEPTH-1:0] sh_q, sh_d;
    logic [SEL_W-1:0]          fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0]          fwd_b_q, fwd_b_d;
    logic                      hit_a, hit_b, ld_a, ld_b;
    logic [SEL_W-1:0]          stg_a, stg_b, sel_a, sel_b;
    logic                      haz_a, haz_b, stall, issue;

    hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
        .ent     (sh_q),
        .src     (bus.id_rs1),
        .use_src (bus.id_use_rs1),
        .hit     (hit_a),
        .stage   (stg_a),
        .is_load (ld_a)
    );

    hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
        .ent     (sh_q),
        .src     (bus.id_rs2),
        .use_src (bus.id_use_rs2),
        .hit     (hit_b),
        .stage   (stg_b),
        .is_load (ld_b)
    );

    // Producer advances one stage by the time the consumer reaches EX.
    function automatic logic [SEL_W:0] resolve(
        input logic             hit,
        input logic [SEL_W-1:0] st,
        input logic             ld
    );
        int nxt;
        nxt = int'(st) + 1;
        if (!hit || nxt >= DEPTH)
            return {1'b0, SEL_W'(SEL_REGFILE)};
        if (ld && nxt < LOAD_STAGE)
            return {1'b1, SEL_W'(SEL_REGFILE)};
        return {1'b0, SEL_W'(nxt)};
    endfunction

    // Interlock, issue decision, shadow shift and next forward selects.
    always_comb begin
        {haz_a, sel_a} = resolve(hit_a, stg_a, ld_a);
        {haz_b, sel_b} = resolve(hit_b, stg_b, ld_b);
        stall = bus.id_valid & (haz_a | haz_b) & ~bus.ex_branch_taken;
        issue = bus.id_valid & ~stall & ~bus.ex_branch_taken;
        sh_d  = '0;
        if (issue && bus.id_wr) begin
            sh_d[0].valid   = 1'b1;
            sh_d[0].rd      = RD_MAX_W'(bus.id_rd);
            sh_d[0].is_load = bus.id_is_load;
        end
        for (int k = 1; k < DEPTH; k++)
            sh_d[k] = sh_q[k-1];
        fwd_a_d = issue ? sel_a : SEL_W'(SEL_REGFILE);
        fwd_b_d = issue ? sel_b : SEL_W'(SEL_REGFILE);
    end

    // Shadow pipeline and registered EX operand selects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q    <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            sh_q    <= sh_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Debug view of which shadow stages hold a pending write.
    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            bus.busy_mask[k] = sh_q[k].valid;
    end

    assign bus.stall       = stall;
    assign bus.flush_if_id = bus.ex_branch_taken;
    assign bus.flush_id_ex = bus.ex_branch_taken;
    assign bus.fwd_a_sel   = fwd_a_q;
    assign bus.fwd_b_sel   = fwd_b_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (bus.ex_branch_taken && flush_count_q != '1)
            flush_count_d = flush_count_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of per-cycle vectors on the
// default configuration plus hand sequences for DEPTH=4/LOAD_STAGE=3 and reset.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       e_stall;
        logic       e_fl;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        logic [2:0] e_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wr, id_is_load, br_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       vt [41];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5), .DEPTH(3)) if3 ();
    pipe_hazard_ctrl_if #(.REG_W(5), .DEPTH(4)) if4 ();

    pipe_hazard_ctrl #(.REG_W(5), .DEPTH(3), .LOAD_STAGE(2)) u_dut3 (
        .clk (clk),
        .rst (rst_n),
        .bus (if3)
    );

    pipe_hazard_ctrl #(.REG_W(5), .DEPTH(4), .LOAD_STAGE(3)) u_dut4 (
        .clk (clk),
        .rst (rst_n),
        .bus (if4)
    );

    assign if3.id_valid        = id_valid;
    assign if3.id_rs1          = id_rs1;
    assign if3.id_rs2          = id_rs2;
    assign if3.id_use_rs1      = id_use_rs1;
    assign if3.id_use_rs2      = id_use_rs2;
    assign if3.id_rd           = id_rd;
    assign if3.id_wr           = id_wr;
    assign if3.id_is_load      = id_is_load;
    assign if3.ex_branch_taken = br_taken;
    assign if4.id_valid        = id_valid;
    assign if4.id_rs1          = id_rs1;
    assign if4.id_rs2          = id_rs2;
    assign if4.id_use_rs1      = id_use_rs1;
    assign if4.id_use_rs2      = id_use_rs2;
    assign if4.id_rd           = id_rd;
    assign if4.id_wr           = id_wr;
    assign if4.id_is_load      = id_is_load;
    assign if4.ex_branch_taken = br_taken;

    function automatic vec_t mk(
        input int v, input int rs1, input int rs2, input int u1, input int u2,
        input int rd, input int wr, input int ld, input int br,
        input int es, input int ef, input int fa, input int fb, input int busy
    );
        vec_t x;
        x.v = 1'(v);       x.rs1 = 5'(rs1);   x.rs2 = 5'(rs2);
        x.u1 = 1'(u1);     x.u2 = 1'(u2);     x.rd = 5'(rd);
        x.wr = 1'(wr);     x.ld = 1'(ld);     x.br = 1'(br);
        x.e_stall = 1'(es); x.e_fl = 1'(ef);
        x.e_fa = 2'(fa);   x.e_fb = 2'(fb);   x.e_busy = 3'(busy);
        return x;
    endfunction

    function automatic vec_t nop(input int fa, input int fb, input int busy);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, busy);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid   = x.v;
        id_rs1     = x.rs1;
        id_rs2     = x.rs2;
        id_use_rs1 = x.u1;
        id_use_rs2 = x.u2;
        id_rd      = x.rd;
        id_wr      = x.wr;
        id_is_load = x.ld;
        br_taken   = x.br;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // args: v rs1 rs2 u1 u2 rd wr ld br | stall flush fa fb busy
        vt[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 3'b000);
        vt[1]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 3'b001);
        vt[2]  = nop(1, 0, 3'b011);
        vt[3]  = mk(1, 3, 4, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 3'b110);
        vt[4]  = nop(0, 2, 3'b101);
        vt[5]  = nop(0, 0, 3'b010);
        vt[6]  = nop(0, 0, 3'b100);
        vt[7]  = nop(0, 0, 3'b000);
        vt[8]  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 3'b000);
        vt[9]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0, 3'b001);
        vt[10] = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 3'b010);
        vt[11] = nop(2, 2, 3'b101);
        vt[12] = nop(0, 0, 3'b010);
        vt[13] = nop(0, 0, 3'b100);
        vt[14] = nop(0, 0, 3'b000);
        vt[15] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3'b000);
        vt[16] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3'b001);
        vt[17] = mk(1, 1, 0, 0, 0, 16, 1, 1, 0, 0, 0, 0, 0, 3'b011);
        vt[18] = mk(1, 16, 16, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 3'b111);
        vt[19] = nop(0, 0, 3'b111);
        vt[20] = nop(0, 0, 3'b110);
        vt[21] = nop(0, 0, 3'b100);
        vt[22] = nop(0, 0, 3'b000);
        vt[23] = mk(1, 1, 2, 1, 1, 17, 1, 0, 0, 0, 0, 0, 0, 3'b000);
        vt[24] = mk(1, 0, 17, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001);
        vt[25] = nop(0, 1, 3'b010);
        vt[26] = nop(0, 0, 3'b100);
        vt[27] = nop(0, 0, 3'b000);
        vt[28] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 3'b000);
        vt[29] = mk(1, 5, 5, 1, 1, 6, 1, 0, 1, 0, 1, 0, 0, 3'b001);
        vt[30] = mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 3'b010);
        vt[31] = nop(0, 0, 3'b101);
        vt[32] = nop(0, 0, 3'b010);
        vt[33] = nop(0, 0, 3'b100);
        vt[34] = nop(0, 0, 3'b000);
        vt[35] = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 3'b000);
        vt[36] = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 3'b001);
        vt[37] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b011);
        vt[38] = nop(1, 0, 3'b110);
        vt[39] = nop(0, 0, 3'b100);
        vt[40] = nop(0, 0, 3'b000);

        rst_n = 1'b0;
        drive(nop(0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(if3.stall), 0);
        chk("reset flush_if_id", 32'(if3.flush_if_id), 0);
        chk("reset flush_id_ex", 32'(if3.flush_id_ex), 0);
        chk("reset fwd_a", 32'(if3.fwd_a_sel), 0);
        chk("reset fwd_b", 32'(if3.fwd_b_sel), 0);
        chk("reset busy", 32'(if3.busy_mask), 0);
        chk("reset busy d4", 32'(if4.busy_mask), 0);
        cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 41; i++) begin
            drive(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d stall", i), 32'(if3.stall), 32'(vt[i].e_stall));
            chk($sformatf("v%0d flush_if_id", i), 32'(if3.flush_if_id), 32'(vt[i].e_fl));
            chk($sformatf("v%0d flush_id_ex", i), 32'(if3.flush_id_ex), 32'(vt[i].e_fl));
            chk($sformatf("v%0d fwd_a", i), 32'(if3.fwd_a_sel), 32'(vt[i].e_fa));
            chk($sformatf("v%0d fwd_b", i), 32'(if3.fwd_b_sel), 32'(vt[i].e_fb));
            chk($sformatf("v%0d busy", i), 32'(if3.busy_mask), 32'(vt[i].e_busy));
            cyc();
        end
`ifdef HAZARD_STATS_EN
        chk("stats stall_cycles", if3.stall_cycles, 1);
        chk("stats flush_count", if3.flush_count, 1);
`endif

        // Clean start for the deeper configuration.
        drive(nop(0, 0, 0));
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        // DEPTH=4, LOAD_STAGE=3: load-use stalls two cycles, then selects 3.
        drive(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("d4 lw stall", 32'(if4.stall), 0);
        cyc();
        drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("d4 use stall1", 32'(if4.stall), 1);
        chk("d3 use stall1", 32'(if3.stall), 1);
        cyc();
        @(negedge clk);
        chk("d4 use stall2", 32'(if4.stall), 1);
        chk("d3 use no stall", 32'(if3.stall), 0);
        cyc();
        @(negedge clk);
        chk("d4 use released", 32'(if4.stall), 0);
        chk("d4 busy", 32'(if4.busy_mask), 32'h4);
        cyc();
        drive(nop(0, 0, 0));
        @(negedge clk);
        chk("d4 fwd_a", 32'(if4.fwd_a_sel), 3);
        chk("d4 fwd_b", 32'(if4.fwd_b_sel), 3);
`ifdef HAZARD_STATS_EN
        chk("d4 stall_cycles", if4.stall_cycles, 2);
`endif
        repeat (4) cyc();

        // Asynchronous reset in the middle of a load-use stall.
        drive(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc();
        drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("pre-reset stall", 32'(if3.stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst stall", 32'(if3.stall), 0);
        chk("async rst busy", 32'(if3.busy_mask), 0);
        chk("async rst fwd_a", 32'(if3.fwd_a_sel), 0);
        chk("async rst fwd_b", 32'(if3.fwd_b_sel), 0);
        chk("async rst stall d4", 32'(if4.stall), 0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst stall", 32'(if3.stall), 0);
        cyc();
        drive(nop(0, 0, 0));
        @(negedge clk);
        chk("post-rst fwd_a", 32'(if3.fwd_a_sel), 0);
        chk("post-rst busy", 32'(if3.busy_mask), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
